mem_port_arbiter: RTL and testbench

// - Shares one 64-bit memory port between instruction fetch (I, requester 0) and the MEM-stage load/store (D, requester 1).
// - Sits between the core's fetch/MEM handshakes and the memory/cache interface.
// - Latches the winning request, holds it on the port until data_ok, then routes the response back to the winner only.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (I, requester 0) and the
//   MEM-stage load/store (D, requester 1). The winning request is latched into
//   the m_* registers. It is held on the port until m_data_ok. The response is
//   then routed back to the winner only.
//
//   Arbitration: fixed D > I priority by default. Define MEM_ARB_RR_EN to get
//   round-robin arbitration, where the requester that did not own the previous
//   grant wins a tie.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   i_valid/i_addr/i_size      fetch request (held until i_data_ok)
//   i_addr_ok/i_data_ok/i_rdata fetch handshake and read data
//   d_valid/d_addr/d_size/d_strobe/d_wdata  load/store request (strobe 0 = load)
//   d_addr_ok/d_data_ok/d_rdata load/store handshake and read data
//   m_valid/m_addr/m_size/m_strobe/m_wdata  registered request to memory
//   m_addr_ok/m_data_ok/m_rdata memory handshake and read data
//   grant                      one-hot owner {D,I}; 2'b00 when idle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [STRB_W-1:0] d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [STRB_W-1:0] m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        grant
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                start_s;   // latch a new request on this edge
  logic                done_s;    // transaction completes on this edge
  logic                pick_d_s;  // D wins the current arbitration
  logic [1:0]          grant_r;
  logic                m_valid_r;
  logic [ADDR_W-1:0]   m_addr_r;
  logic [2:0]          m_size_r;
  logic [STRB_W-1:0]   m_strobe_r;
  logic [DATA_W-1:0]   m_wdata_r;

  // Next-state logic: accept a request in IDLE, finish on m_data_ok in BUSY.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_valid || d_valid) begin
          state_s = BUSY;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (m_data_ok) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_RR_EN
  logic last_owner_r;  // 1'b0 = I, 1'b1 = D

  // Round-robin pick: on a tie the requester that did not own the last grant wins.
  always_comb begin
    if (i_valid && d_valid) begin
      pick_d_s = (last_owner_r == 1'b0);
    end else begin
      pick_d_s = d_valid;
    end
  end

  // Remember the owner of every grant for the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_r <= 1'b0;
    end else if (start_s) begin
      last_owner_r <= pick_d_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Fixed priority pick: D always beats I.
  always_comb begin
    pick_d_s = d_valid;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch: fields captured on grant, held stable until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_r    <= 2'b00;
      m_valid_r  <= 1'b0;
      m_addr_r   <= {ADDR_W{1'b0}};
      m_size_r   <= 3'b000;
      m_strobe_r <= {STRB_W{1'b0}};
      m_wdata_r  <= {DATA_W{1'b0}};
    end else if (start_s) begin
      grant_r    <= pick_d_s ? 2'b10 : 2'b01;
      m_valid_r  <= 1'b1;
      m_addr_r   <= pick_d_s ? d_addr : i_addr;
      m_size_r   <= pick_d_s ? d_size : i_size;
      // Fetches never write.
      m_strobe_r <= pick_d_s ? d_strobe : {STRB_W{1'b0}};
      m_wdata_r  <= pick_d_s ? d_wdata : {DATA_W{1'b0}};
    end else if (done_s) begin
      grant_r    <= 2'b00;
      m_valid_r  <= 1'b0;
    end else begin
      grant_r    <= grant_r;
      m_valid_r  <= m_valid_r;
    end
  end

  // grant is only non-zero in BUSY, so memory responses in IDLE are dropped.
  assign grant     = grant_r;
  assign m_valid   = m_valid_r;
  assign m_addr    = m_addr_r;
  assign m_size    = m_size_r;
  assign m_strobe  = m_strobe_r;
  assign m_wdata   = m_wdata_r;
  assign i_addr_ok = m_addr_ok & grant_r[0];
  assign d_addr_ok = m_addr_ok & grant_r[1];
  assign i_data_ok = m_data_ok & grant_r[0];
  assign d_data_ok = m_data_ok & grant_r[1];
  assign i_rdata   = grant_r[0] ? m_rdata : {DATA_W{1'b0}};
  assign d_rdata   = grant_r[1] ? m_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic [2:0]  i_size;
  logic        i_addr_ok, i_data_ok;
  logic [63:0] i_rdata;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [63:0] m_rdata;
  logic [1:0]  grant;

  typedef struct packed {
    logic        port;   // 0 = I, 1 = D
    logic [63:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_size(i_size),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every data_ok pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (i_data_ok || d_data_ok) begin
      checks++;
      if (i_data_ok && d_data_ok) begin
        errors++;
        $display("FAIL resp_both: i_data_ok=1 d_data_ok=1 expected one-hot");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: i_data_ok=%0b d_data_ok=%0b expected none", i_data_ok, d_data_ok);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (d_data_ok !== e.port) begin
          errors++;
          $display("FAIL resp_port: got d=%0b expected d=%0b", d_data_ok, e.port);
        end else if ((e.port ? d_rdata : i_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL resp_rdata: got 0x%0h expected 0x%0h", e.port ? d_rdata : i_rdata, e.rdata);
        end else if ((e.port ? i_rdata : d_rdata) !== 64'h0) begin
          errors++;
          $display("FAIL loser_rdata: got 0x%0h expected 0x0", e.port ? i_rdata : d_rdata);
        end
      end
    end
  end

  // Called just after the edge that moved the DUT to BUSY: checks the latched
  // request, then completes it with an addr_ok cycle and a data_ok cycle.
  task automatic serve(input string name, input logic [1:0] g, input logic [63:0] a,
                       input logic [7:0] s, input logic [63:0] w, input logic [63:0] rd);
    m_addr_ok = 1'b1;
    @(negedge clk);
    check({name, "_grant"},   {62'h0, grant}, {62'h0, g});
    check({name, "_m_valid"}, {63'h0, m_valid}, 64'h1);
    check({name, "_m_addr"},  m_addr, a);
    check({name, "_m_strobe"},{56'h0, m_strobe}, {56'h0, s});
    check({name, "_m_wdata"}, m_wdata, w);
    check({name, "_addr_ok"}, {62'h0, d_addr_ok, i_addr_ok}, {62'h0, g});
    step();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b1;
    m_rdata   = rd;
    @(negedge clk);
    check({name, "_hold_addr"}, m_addr, a);
    step();
    m_data_ok = 1'b0;
    m_rdata   = 64'h0;
  endtask

  logic first_d;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_addr = 64'h0; i_size = 3'd0;
    d_valid = 1'b0; d_addr = 64'h0; d_size = 3'd0; d_strobe = 8'h0; d_wdata = 64'h0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 64'h0;

    // Reset state.
    @(negedge clk);
    check("rst_grant",   {62'h0, grant}, 64'h0);
    check("rst_m_valid", {63'h0, m_valid}, 64'h0);
    check("rst_m_addr",  m_addr, 64'h0);
    check("rst_m_size",  {61'h0, m_size}, 64'h0);
    check("rst_m_strobe",{56'h0, m_strobe}, 64'h0);
    check("rst_m_wdata", m_wdata, 64'h0);
    step();
    reset = 1'b0;
    step();

    // Single fetch.
    i_valid = 1'b1; i_addr = 64'h8000_0000; i_size = 3'd3;
    sb_q.push_back('{port: 1'b0, rdata: 64'h13});
    step();
    serve("fetch", 2'b01, 64'h8000_0000, 8'h00, 64'h0, 64'h13);
    i_valid = 1'b0;
    @(negedge clk);
    check("fetch_idle_grant", {62'h0, grant}, 64'h0);
    check("fetch_m_size", {61'h0, m_size}, 64'h3);
    step();

    // Store.
    d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd3;
    d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF;
    sb_q.push_back('{port: 1'b1, rdata: 64'h0});
    step();
    serve("store", 2'b10, 64'h8000_1000, 8'hFF, 64'hDEAD_BEEF, 64'h0);
    d_valid = 1'b0;
    step();

    // Simultaneous requests; last owner is D here.
`ifdef MEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    i_valid = 1'b1; i_addr = 64'h8000_0040; i_size = 3'd2;
    d_valid = 1'b1; d_addr = 64'h8000_2000; d_size = 3'd3;
    d_strobe = 8'h00; d_wdata = 64'h1234;
    if (first_d) begin
      sb_q.push_back('{port: 1'b1, rdata: 64'hAAAA});
      sb_q.push_back('{port: 1'b0, rdata: 64'hBBBB});
      step();
      serve("both_d", 2'b10, 64'h8000_2000, 8'h00, 64'h1234, 64'hAAAA);
      d_valid = 1'b0;
    end else begin
      sb_q.push_back('{port: 1'b0, rdata: 64'hBBBB});
      sb_q.push_back('{port: 1'b1, rdata: 64'hAAAA});
      step();
      serve("both_i", 2'b01, 64'h8000_0040, 8'h00, 64'h0, 64'hBBBB);
      i_valid = 1'b0;
    end
    // One dead IDLE cycle between the two transactions.
    @(negedge clk);
    check("both_dead_grant", {62'h0, grant}, 64'h0);
    check("both_dead_valid", {63'h0, m_valid}, 64'h0);
    step();
    if (first_d) begin
      serve("both_i", 2'b01, 64'h8000_0040, 8'h00, 64'h0, 64'hBBBB);
      i_valid = 1'b0;
    end else begin
      serve("both_d", 2'b10, 64'h8000_2000, 8'h00, 64'h1234, 64'hAAAA);
      d_valid = 1'b0;
    end
    step();

    // Load whose valid drops while BUSY.
    d_valid = 1'b1; d_addr = 64'h100; d_size = 3'd2; d_strobe = 8'h00; d_wdata = 64'h0;
    sb_q.push_back('{port: 1'b1, rdata: 64'hABCD});
    step();
    d_valid = 1'b0; d_addr = 64'h999;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("drop_hold_addr", m_addr, 64'h100);
      check("drop_hold_valid", {63'h0, m_valid}, 64'h1);
      step();
    end
    serve("drop", 2'b10, 64'h100, 8'h00, 64'h0, 64'hABCD);
    step();

    // Reset while BUSY.
    i_valid = 1'b1; i_addr = 64'h8000_0080;
    step();
    step();
    reset = 1'b1;
    #1;
    check("rstbusy_m_valid", {63'h0, m_valid}, 64'h0);
    check("rstbusy_grant", {62'h0, grant}, 64'h0);
    check("rstbusy_m_addr", m_addr, 64'h0);
    i_valid = 1'b0;
    step();
    reset = 1'b0;
    m_data_ok = 1'b1; m_rdata = 64'h55;
    step();
    m_data_ok = 1'b0; m_rdata = 64'h0;
    @(negedge clk);
    check("rstbusy_after_grant", {62'h0, grant}, 64'h0);
    step();

    // m_data_ok in IDLE is ignored.
    m_data_ok = 1'b1; m_rdata = 64'h77;
    @(negedge clk);
    check("idle_dok_grant", {62'h0, grant}, 64'h0);
    step();
    m_data_ok = 1'b0; m_rdata = 64'h0;
    @(negedge clk);
    check("idle_dok_valid", {63'h0, m_valid}, 64'h0);
    step();

    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
